ym6046_io_ctrl: RTL and testbench
=================================

Name: ym6046_io_ctrl

Overview:
- CPU-side sequencer for the three controller-port/UART datapaths of the I/O chip (ports A, B, C).
- Decodes register accesses into one-MCLK write/read strobes and returns registered read data.
- Generates the four two-phase UART baud tick pairs consumed by each port.
- Arbitrates the six port interrupt sources (TH/b6 and UART per port) into one prioritised request with acknowledge.

Parameters:
- VERSION, 4'h0, value returned in version register bits [3:0].
- BASE_DIV, 11186, MCLK cycles per base (4800-baud) tick; legal range 4..16383, must be even.

Ports:
- MCLK  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_sel  in  1  chip-select for the I/O register window.
- cpu_wr  in  1  write enable, qualified by cpu_sel.
- cpu_rd  in  1  read enable, qualified by cpu_sel.
- cpu_addr  in  4  register index: 0 version; 1-3 data A-C; 4-6 control A-C; 7/8/9 tx/rx/sctrl A; 10/11/12 B; 13/14/15 C.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  registered read data.
- overseas, pal, disk  in  1 each  version-register straps.
- p_data_q, p_control_q, p_tx_data, p_rx_data_q  in  24 each  per-port register values, port A in [7:0], B in [15:8], C in [23:16].
- s_status  in  24  per port {s_control_q[4:0], rx_error_q, rx_ready_q, tx_state1_q}.
- irq_b6, irq_uart  in  3 each  per-port interrupt levels.
- data_bus  out  8  held write data to ports.
- write_p_data, write_p_control, write_tx_data, write_s_control, read_rx_data  out  3 each  one-hot port strobes.
- uart_clk_i1, uart_clk_i2  out  4 each  baud phase ticks; index 0..3 = 4800/2400/1200/300.
- irq  out  1  any pending interrupt.
- irq_src  out  3  index of highest-priority pending source.
- irq_ack  in  1  clears the pending source named by irq_src.

Behaviour:
- Reset (reset=0, async): all outputs 0. Counters, pending bits, edge-detect flops and data_bus cleared.
- Access detect: acc_wr = cpu_sel&cpu_wr and acc_rd = cpu_sel&cpu_rd each registered once.
  - A 0->1 transition of the registered copy is one access.
  - Holding the enable high produces no further strobes.
- Write:
  - On the detect cycle, data_bus <= cpu_wdata.
  - On the next cycle, exactly one strobe bit is high for one MCLK, selected by cpu_addr latched at the detect cycle.
  - data_bus stays held until the next write. Latency from the wr rise to the strobe is 2 MCLK.
  - Writes to 0, 8, 11 and 14 produce no strobe.
- Read:
  - On the detect cycle, cpu_rdata <= mux(cpu_addr); the value is valid 2 MCLK after the rd rise and holds until the next read.
  - Address 0 returns {overseas, pal, ~disk, 1'b0, VERSION}.
  - Address 9/12/15 returns s_status of that port.
  - A read of 8/11/14 also pulses read_rx_data for that port one cycle after the rdata update.
- Simultaneous wr and rd rise: the write is taken, the read is ignored.
- Baud generator:
  - bc counts 0..BASE_DIV-1 and wraps.
  - rc is a 4-bit counter that increments when bc wraps.
  - Masks are m0=0, m1=1, m2=3, m3=15.
  - uart_clk_i2[k] pulses one MCLK when bc==BASE_DIV-1 and (rc&mk)==mk.
  - uart_clk_i1[k] pulses one MCLK when bc==BASE_DIV/2-1 and (rc&mk)==mk.
  - The i1 pulse therefore precedes the i2 pulse by BASE_DIV/2 cycles. Period of rate k = BASE_DIV*(1,2,4,16).
  - rc wraps 15->0 with no glitch. The generator is free-running and unaffected by register traffic.
- IRQ arbiter:
  - Six sources in priority order: 0 A.b6, 1 A.uart, 2 B.b6, 3 B.uart, 4 C.b6, 5 C.uart.
  - Each source's level is registered; a rising edge sets its pending bit.
  - irq = |pending; irq_src = lowest set index, and is 0 when none is pending.
  - irq_ack clears pending[irq_src] at that edge. If the same source produces a new rising edge in that same cycle, set wins.
  - Ack with nothing pending has no effect.
- Reset mid-operation: an in-flight strobe is cancelled, baud phase restarts from bc=0/rc=0, and pending bits are lost.

Decomposition:
- Shared package ym6046_pkg holds:
  - register-index constants (REG_VERSION..REG_SCTRL_C);
  - IRQ source indices;
  - rate index constants RATE_4800..RATE_300;
  - rate mask table.
- One natural sub-module: ym6046_baud_gen (bc/rc counters and the i1/i2 tick outputs), parameterised by BASE_DIV.

Test Plan:
- Version read: overseas=1, pal=0, disk=0, VERSION=4'h2; read addr 0 -> cpu_rdata=8'hA2, 2 MCLK after the rd rise.
- Write strobe: write 8'h40 to addr 5, holding wr 10 cycles -> data_bus=8'h40 and write_p_control=3'b010 for exactly 1 MCLK, 2 cycles after the wr rise, no repeat. Write to addr 8 -> no strobe.
- Rx read: read addr 11 with p_rx_data_q[15:8]=8'h5A -> cpu_rdata=8'h5A; read_rx_data=3'b010 for one cycle, the cycle after.
- Baud (BASE_DIV=8): i2[0] every 8 cycles, i2[3] every 128. i1[k] lands 4 cycles before each i2[k]. After 16 base ticks rc wraps with no missing or extra pulse.
- IRQ: raise irq_uart[2] and irq_b6[0] in the same cycle -> irq=1, irq_src=0. Ack -> irq_src=5. Ack again -> irq=0. Ack coinciding with a new edge on the same source -> stays pending.
- Reset mid-op: assert reset between detect and strobe -> no strobe, all outputs 0. After release, first i2[0] occurs at cycle BASE_DIV.

Source files
------------

// File: rtl/ym6046_pkg.sv
// Shared definitions for the YM6046 I/O controller: register map, IRQ source
// indices, baud rate indices and small decode helpers.
package ym6046_pkg;

  localparam logic [3:0] REG_VERSION = 4'd0;
  localparam logic [3:0] REG_DATA_A  = 4'd1;
  localparam logic [3:0] REG_DATA_B  = 4'd2;
  localparam logic [3:0] REG_DATA_C  = 4'd3;
  localparam logic [3:0] REG_CTRL_A  = 4'd4;
  localparam logic [3:0] REG_CTRL_B  = 4'd5;
  localparam logic [3:0] REG_CTRL_C  = 4'd6;
  localparam logic [3:0] REG_TX_A    = 4'd7;
  localparam logic [3:0] REG_RX_A    = 4'd8;
  localparam logic [3:0] REG_SCTRL_A = 4'd9;
  localparam logic [3:0] REG_TX_B    = 4'd10;
  localparam logic [3:0] REG_RX_B    = 4'd11;
  localparam logic [3:0] REG_SCTRL_B = 4'd12;
  localparam logic [3:0] REG_TX_C    = 4'd13;
  localparam logic [3:0] REG_RX_C    = 4'd14;
  localparam logic [3:0] REG_SCTRL_C = 4'd15;

  localparam logic [2:0] IRQ_A_B6   = 3'd0;
  localparam logic [2:0] IRQ_A_UART = 3'd1;
  localparam logic [2:0] IRQ_B_B6   = 3'd2;
  localparam logic [2:0] IRQ_B_UART = 3'd3;
  localparam logic [2:0] IRQ_C_B6   = 3'd4;
  localparam logic [2:0] IRQ_C_UART = 3'd5;
  localparam int         NUM_IRQ    = 6;

  localparam logic [1:0] RATE_4800 = 2'd0;
  localparam logic [1:0] RATE_2400 = 2'd1;
  localparam logic [1:0] RATE_1200 = 2'd2;
  localparam logic [1:0] RATE_300  = 2'd3;
  localparam int         NUM_RATES = 4;

  typedef enum logic [2:0] {
    KIND_VERSION,
    KIND_DATA,
    KIND_CTRL,
    KIND_TX,
    KIND_RX,
    KIND_SCTRL
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [1:0] port;
  } reg_dec_t;

  function automatic reg_dec_t reg_decode(input logic [3:0] addr);
    reg_dec_t d;
    d.kind = KIND_VERSION;
    d.port = 2'd0;
    case (addr)
      REG_DATA_A:  begin d.kind = KIND_DATA;  d.port = 2'd0; end
      REG_DATA_B:  begin d.kind = KIND_DATA;  d.port = 2'd1; end
      REG_DATA_C:  begin d.kind = KIND_DATA;  d.port = 2'd2; end
      REG_CTRL_A:  begin d.kind = KIND_CTRL;  d.port = 2'd0; end
      REG_CTRL_B:  begin d.kind = KIND_CTRL;  d.port = 2'd1; end
      REG_CTRL_C:  begin d.kind = KIND_CTRL;  d.port = 2'd2; end
      REG_TX_A:    begin d.kind = KIND_TX;    d.port = 2'd0; end
      REG_RX_A:    begin d.kind = KIND_RX;    d.port = 2'd0; end
      REG_SCTRL_A: begin d.kind = KIND_SCTRL; d.port = 2'd0; end
      REG_TX_B:    begin d.kind = KIND_TX;    d.port = 2'd1; end
      REG_RX_B:    begin d.kind = KIND_RX;    d.port = 2'd1; end
      REG_SCTRL_B: begin d.kind = KIND_SCTRL; d.port = 2'd1; end
      REG_TX_C:    begin d.kind = KIND_TX;    d.port = 2'd2; end
      REG_RX_C:    begin d.kind = KIND_RX;    d.port = 2'd2; end
      REG_SCTRL_C: begin d.kind = KIND_SCTRL; d.port = 2'd2; end
      default:     begin d.kind = KIND_VERSION; d.port = 2'd0; end
    endcase
    return d;
  endfunction

  // A rate fires on the base ticks where the low bits of the tick count are all ones.
  function automatic logic [3:0] rate_mask(input logic [1:0] rate);
    case (rate)
      RATE_4800: return 4'h0;
      RATE_2400: return 4'h1;
      RATE_1200: return 4'h3;
      RATE_300:  return 4'hF;
      default:   return 4'h0;
    endcase
  endfunction

  function automatic logic [7:0] port_byte(input logic [23:0] v, input logic [1:0] port);
    case (port)
      2'd0:    return v[7:0];
      2'd1:    return v[15:8];
      default: return v[23:16];
    endcase
  endfunction

endpackage

// File: rtl/ym6046_baud_gen.sv
// Free-running UART baud generator: base divider plus a 4-bit tick counter
// producing two-phase ticks for 4800/2400/1200/300 baud.
module ym6046_baud_gen
  import ym6046_pkg::*;
#(
  parameter int BASE_DIV = 11186
) (
  input  logic       MCLK,
  input  logic       reset,
  output logic [3:0] uart_clk_i1,
  output logic [3:0] uart_clk_i2
);

  localparam logic [13:0] BC_LAST = 14'(BASE_DIV - 1);
  localparam logic [13:0] BC_HALF = 14'(BASE_DIV / 2 - 1);

  logic [13:0] r_bc;
  logic [3:0]  r_rc;
  logic        w_last;
  logic        w_half;

  assign w_last = (r_bc == BC_LAST);
  assign w_half = (r_bc == BC_HALF);

  // Ticks are registered, so they appear one MCLK after the matching count.
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      r_bc        <= '0;
      r_rc        <= '0;
      uart_clk_i1 <= '0;
      uart_clk_i2 <= '0;
    end else begin
      if (w_last) begin
        r_bc <= '0;
        r_rc <= r_rc + 4'd1;
      end else begin
        r_bc <= r_bc + 14'd1;
      end
      for (int k = 0; k < NUM_RATES; k++) begin
        uart_clk_i2[k] <= w_last && ((r_rc & rate_mask(2'(k))) == rate_mask(2'(k)));
        uart_clk_i1[k] <= w_half && ((r_rc & rate_mask(2'(k))) == rate_mask(2'(k)));
      end
    end
  end

endmodule

// File: rtl/ym6046_io_ctrl.sv
// CPU-side sequencer for the three controller/UART ports: register access
// strobes, read-back mux, baud tick generation and interrupt arbitration.
module ym6046_io_ctrl
  import ym6046_pkg::*;
#(
  parameter logic [3:0] VERSION  = 4'h0,
  parameter int         BASE_DIV = 11186
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        cpu_sel,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [3:0]  cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        overseas,
  input  logic        pal,
  input  logic        disk,
  input  logic [23:0] p_data_q,
  input  logic [23:0] p_control_q,
  input  logic [23:0] p_tx_data,
  input  logic [23:0] p_rx_data_q,
  input  logic [23:0] s_status,
  input  logic [2:0]  irq_b6,
  input  logic [2:0]  irq_uart,
  output logic [7:0]  data_bus,
  output logic [2:0]  write_p_data,
  output logic [2:0]  write_p_control,
  output logic [2:0]  write_tx_data,
  output logic [2:0]  write_s_control,
  output logic [2:0]  read_rx_data,
  output logic [3:0]  uart_clk_i1,
  output logic [3:0]  uart_clk_i2,
  output logic        irq,
  output logic [2:0]  irq_src,
  input  logic        irq_ack
);

  logic             r_acc_wr;
  logic             r_acc_wr_d;
  logic             r_acc_rd;
  logic             r_acc_rd_d;
  logic [2:0]       r_rx_pend;
  logic [NUM_IRQ-1:0] r_lvl;
  logic [NUM_IRQ-1:0] r_lvl_d;
  logic [NUM_IRQ-1:0] r_pend;

  logic             w_wr_rise;
  logic             w_rd_rise;
  reg_dec_t         w_dec;
  logic [2:0]       w_port_oh;
  logic [7:0]       w_rd_mux;
  logic [NUM_IRQ-1:0] w_irq_lvl;
  logic [NUM_IRQ-1:0] w_irq_rise;
  logic [NUM_IRQ-1:0] w_ack_mask;
  logic [2:0]       w_irq_src;

  assign w_wr_rise = r_acc_wr & ~r_acc_wr_d;
  // A write wins over a read that rises on the same cycle.
  assign w_rd_rise = r_acc_rd & ~r_acc_rd_d & ~w_wr_rise;
  assign w_dec     = reg_decode(cpu_addr);
  assign w_port_oh = 3'b001 << w_dec.port;

  always_comb begin
    w_rd_mux = 8'h00;
    case (w_dec.kind)
      KIND_VERSION: w_rd_mux = {overseas, pal, ~disk, 1'b0, VERSION};
      KIND_DATA:    w_rd_mux = port_byte(p_data_q, w_dec.port);
      KIND_CTRL:    w_rd_mux = port_byte(p_control_q, w_dec.port);
      KIND_TX:      w_rd_mux = port_byte(p_tx_data, w_dec.port);
      KIND_RX:      w_rd_mux = port_byte(p_rx_data_q, w_dec.port);
      KIND_SCTRL:   w_rd_mux = port_byte(s_status, w_dec.port);
      default:      w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      r_acc_wr        <= 1'b0;
      r_acc_wr_d      <= 1'b0;
      r_acc_rd        <= 1'b0;
      r_acc_rd_d      <= 1'b0;
      r_rx_pend       <= '0;
      data_bus        <= '0;
      cpu_rdata       <= '0;
      write_p_data    <= '0;
      write_p_control <= '0;
      write_tx_data   <= '0;
      write_s_control <= '0;
      read_rx_data    <= '0;
    end else begin
      r_acc_wr   <= cpu_sel & cpu_wr;
      r_acc_wr_d <= r_acc_wr;
      r_acc_rd   <= cpu_sel & cpu_rd;
      r_acc_rd_d <= r_acc_rd;

      write_p_data    <= (w_wr_rise && w_dec.kind == KIND_DATA)  ? w_port_oh : 3'b000;
      write_p_control <= (w_wr_rise && w_dec.kind == KIND_CTRL)  ? w_port_oh : 3'b000;
      write_tx_data   <= (w_wr_rise && w_dec.kind == KIND_TX)    ? w_port_oh : 3'b000;
      write_s_control <= (w_wr_rise && w_dec.kind == KIND_SCTRL) ? w_port_oh : 3'b000;
      if (w_wr_rise) begin
        data_bus <= cpu_wdata;
      end

      // The rx-consume pulse trails the rdata update so the port pops after the byte is captured.
      r_rx_pend    <= (w_rd_rise && w_dec.kind == KIND_RX) ? w_port_oh : 3'b000;
      read_rx_data <= r_rx_pend;
      if (w_rd_rise) begin
        cpu_rdata <= w_rd_mux;
      end
    end
  end

  ym6046_baud_gen #(
    .BASE_DIV (BASE_DIV)
  ) u_baud (
    .MCLK        (MCLK),
    .reset       (reset),
    .uart_clk_i1 (uart_clk_i1),
    .uart_clk_i2 (uart_clk_i2)
  );

  always_comb begin
    w_irq_lvl             = '0;
    w_irq_lvl[IRQ_A_B6]   = irq_b6[0];
    w_irq_lvl[IRQ_A_UART] = irq_uart[0];
    w_irq_lvl[IRQ_B_B6]   = irq_b6[1];
    w_irq_lvl[IRQ_B_UART] = irq_uart[1];
    w_irq_lvl[IRQ_C_B6]   = irq_b6[2];
    w_irq_lvl[IRQ_C_UART] = irq_uart[2];
  end

  assign w_irq_rise = r_lvl & ~r_lvl_d;

  // Scan from the top so the lowest pending index is the one left standing.
  always_comb begin
    w_irq_src = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_irq_src = 3'(i);
      end
    end
  end

  assign w_ack_mask = irq_ack ? (NUM_IRQ'(1) << w_irq_src) : '0;

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      r_lvl   <= '0;
      r_lvl_d <= '0;
      r_pend  <= '0;
    end else begin
      r_lvl   <= w_irq_lvl;
      r_lvl_d <= r_lvl;
      r_pend  <= (r_pend & ~w_ack_mask) | w_irq_rise;
    end
  end

  assign irq     = |r_pend;
  assign irq_src = w_irq_src;

endmodule

// File: tb/tb_ym6046_io_ctrl.sv
// Directed bench for ym6046_io_ctrl with VERSION=2 and BASE_DIV=8.
module tb_ym6046_io_ctrl;

  logic        MCLK;
  logic        reset;
  logic        cpu_sel, cpu_wr, cpu_rd;
  logic [3:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        overseas, pal, disk;
  logic [23:0] p_data_q, p_control_q, p_tx_data, p_rx_data_q, s_status;
  logic [2:0]  irq_b6, irq_uart;
  logic [7:0]  data_bus;
  logic [2:0]  write_p_data, write_p_control, write_tx_data, write_s_control, read_rx_data;
  logic [3:0]  uart_clk_i1, uart_clk_i2;
  logic        irq;
  logic [2:0]  irq_src;
  logic        irq_ack;

  int checks;
  int errors;

  logic [3:0] rd_addr_tbl [8];
  logic [7:0] rd_exp_tbl  [8];

  ym6046_io_ctrl #(
    .VERSION  (4'h2),
    .BASE_DIV (8)
  ) dut (
    .MCLK            (MCLK),
    .reset           (reset),
    .cpu_sel         (cpu_sel),
    .cpu_wr          (cpu_wr),
    .cpu_rd          (cpu_rd),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .overseas        (overseas),
    .pal             (pal),
    .disk            (disk),
    .p_data_q        (p_data_q),
    .p_control_q     (p_control_q),
    .p_tx_data       (p_tx_data),
    .p_rx_data_q     (p_rx_data_q),
    .s_status        (s_status),
    .irq_b6          (irq_b6),
    .irq_uart        (irq_uart),
    .data_bus        (data_bus),
    .write_p_data    (write_p_data),
    .write_p_control (write_p_control),
    .write_tx_data   (write_tx_data),
    .write_s_control (write_s_control),
    .read_rx_data    (read_rx_data),
    .uart_clk_i1     (uart_clk_i1),
    .uart_clk_i2     (uart_clk_i2),
    .irq             (irq),
    .irq_src         (irq_src),
    .irq_ack         (irq_ack)
  );

  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic bus_idle();
    cpu_sel = 1'b0;
    cpu_wr  = 1'b0;
    cpu_rd  = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_rdata: got %h want 00", cpu_rdata);
    end
    checks++;
    if (data_bus !== 8'h00) begin
      errors++; $display("FAIL reset_data_bus: got %h want 00", data_bus);
    end
    checks++;
    if ({write_p_data, write_p_control, write_tx_data, write_s_control, read_rx_data} !== 15'h0) begin
      errors++; $display("FAIL reset_strobes: got %h want 0",
                         {write_p_data, write_p_control, write_tx_data, write_s_control, read_rx_data});
    end
    checks++;
    if ({uart_clk_i1, uart_clk_i2} !== 8'h00) begin
      errors++; $display("FAIL reset_ticks: got %h want 00", {uart_clk_i1, uart_clk_i2});
    end
    checks++;
    if ({irq, irq_src} !== 4'h0) begin
      errors++; $display("FAIL reset_irq: got %b/%0d want 0/0", irq, irq_src);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_version();
    cpu_addr = 4'd0;
    cpu_sel  = 1'b1;
    cpu_rd   = 1'b1;
    tick();
    checks++;
    if (cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL version_early: got %h want 00 at cycle 1", cpu_rdata);
    end
    tick();
    checks++;
    if (cpu_rdata !== 8'hA2) begin
      errors++; $display("FAIL version_read: got %h want A2", cpu_rdata);
    end
    bus_idle();
    tick();
    tick();
  endtask

  task automatic test_write_strobe();
    cpu_addr  = 4'd5;
    cpu_wdata = 8'h40;
    cpu_sel   = 1'b1;
    cpu_wr    = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if (write_p_control !== ((c == 2) ? 3'b010 : 3'b000)) begin
        errors++; $display("FAIL wr_ctrl_strobe cycle %0d: got %b want %b",
                           c, write_p_control, (c == 2) ? 3'b010 : 3'b000);
      end
      checks++;
      if ({write_p_data, write_tx_data, write_s_control} !== 9'h0) begin
        errors++; $display("FAIL wr_other_strobes cycle %0d: got %h want 0",
                           c, {write_p_data, write_tx_data, write_s_control});
      end
      if (c == 2) begin
        checks++;
        if (data_bus !== 8'h40) begin
          errors++; $display("FAIL wr_data_bus: got %h want 40", data_bus);
        end
      end
    end
    bus_idle();
    tick();
    tick();
    cpu_addr  = 4'd8;
    cpu_wdata = 8'h33;
    cpu_sel   = 1'b1;
    cpu_wr    = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++;
      if ({write_p_data, write_p_control, write_tx_data, write_s_control, read_rx_data} !== 15'h0) begin
        errors++; $display("FAIL wr_rx_no_strobe cycle %0d: got %h want 0", c,
                           {write_p_data, write_p_control, write_tx_data, write_s_control, read_rx_data});
      end
    end
    checks++;
    if (data_bus !== 8'h33) begin
      errors++; $display("FAIL wr_rx_data_bus: got %h want 33", data_bus);
    end
    bus_idle();
    tick();
    tick();
  endtask

  task automatic test_rx_read();
    p_rx_data_q = 24'h11_5A_22;
    cpu_addr    = 4'd11;
    cpu_sel     = 1'b1;
    cpu_rd      = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c >= 2) begin
        checks++;
        if (cpu_rdata !== 8'h5A) begin
          errors++; $display("FAIL rx_rdata cycle %0d: got %h want 5A", c, cpu_rdata);
        end
      end
      checks++;
      if (read_rx_data !== ((c == 3) ? 3'b010 : 3'b000)) begin
        errors++; $display("FAIL rx_pulse cycle %0d: got %b want %b",
                           c, read_rx_data, (c == 3) ? 3'b010 : 3'b000);
      end
    end
    bus_idle();
    tick();
    tick();
  endtask

  task automatic test_reg_reads();
    p_data_q    = 24'h33_44_55;
    p_control_q = 24'hA1_B2_C3;
    p_tx_data   = 24'h0F_1E_2D;
    s_status    = 24'hC3_96_0F;
    rd_addr_tbl = '{4'd1, 4'd3, 4'd4, 4'd6, 4'd10, 4'd9, 4'd12, 4'd15};
    rd_exp_tbl  = '{8'h55, 8'h33, 8'hC3, 8'hA1, 8'h1E, 8'h0F, 8'h96, 8'hC3};
    for (int i = 0; i < 8; i++) begin
      cpu_addr = rd_addr_tbl[i];
      cpu_sel  = 1'b1;
      cpu_rd   = 1'b1;
      tick();
      tick();
      checks++;
      if (cpu_rdata !== rd_exp_tbl[i]) begin
        errors++; $display("FAIL reg_read addr %0d: got %h want %h", rd_addr_tbl[i], cpu_rdata, rd_exp_tbl[i]);
      end
      bus_idle();
      tick();
      checks++;
      if (read_rx_data !== 3'b000) begin
        errors++; $display("FAIL reg_read_no_rx addr %0d: got %b want 000", rd_addr_tbl[i], read_rx_data);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    cpu_addr  = 4'd2;
    cpu_wdata = 8'h77;
    cpu_sel   = 1'b1;
    cpu_wr    = 1'b1;
    cpu_rd    = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (write_p_data !== ((c == 2) ? 3'b010 : 3'b000)) begin
        errors++; $display("FAIL simul_wr_strobe cycle %0d: got %b want %b",
                           c, write_p_data, (c == 2) ? 3'b010 : 3'b000);
      end
      checks++;
      if (cpu_rdata !== 8'hC3) begin
        errors++; $display("FAIL simul_rd_ignored cycle %0d: got %h want C3", c, cpu_rdata);
      end
    end
    checks++;
    if (data_bus !== 8'h77) begin
      errors++; $display("FAIL simul_data_bus: got %h want 77", data_bus);
    end
    bus_idle();
    tick();
    tick();
  endtask

  task automatic test_irq();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if ({irq, irq_src} !== 4'h0) begin
      errors++; $display("FAIL irq_ack_idle: got %b/%0d want 0/0", irq, irq_src);
    end
    irq_uart[2] = 1'b1;
    irq_b6[0]   = 1'b1;
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_latency: got %b want 0 after one cycle", irq);
    end
    tick();
    checks++;
    if ({irq, irq_src} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL irq_two_src: got %b/%0d want 1/0", irq, irq_src);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if ({irq, irq_src} !== {1'b1, 3'd5}) begin
      errors++; $display("FAIL irq_after_ack1: got %b/%0d want 1/5", irq, irq_src);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if ({irq, irq_src} !== 4'h0) begin
      errors++; $display("FAIL irq_after_ack2: got %b/%0d want 0/0", irq, irq_src);
    end
    irq_b6[1] = 1'b1;
    tick();
    tick();
    checks++;
    if ({irq, irq_src} !== {1'b1, 3'd2}) begin
      errors++; $display("FAIL irq_b_b6: got %b/%0d want 1/2", irq, irq_src);
    end
    irq_b6[1] = 1'b0;
    tick();
    tick();
    irq_b6[1] = 1'b1;
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if ({irq, irq_src} !== {1'b1, 3'd2}) begin
      errors++; $display("FAIL irq_ack_vs_set: got %b/%0d want 1/2", irq, irq_src);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_final_clear: got %b want 0", irq);
    end
    irq_b6   = 3'b000;
    irq_uart = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_reset_midop();
    int first_i2;
    cpu_addr  = 4'd1;
    cpu_wdata = 8'h5C;
    cpu_sel   = 1'b1;
    cpu_wr    = 1'b1;
    tick();
    tick();
    bus_idle();
    irq_b6[2] = 1'b1;
    tick();
    tick();
    checks++;
    if ({irq, irq_src, data_bus} !== {1'b1, 3'd4, 8'h5C}) begin
      errors++; $display("FAIL midop_setup: got irq %b src %0d bus %h want 1/4/5C", irq, irq_src, data_bus);
    end
    cpu_addr  = 4'd4;
    cpu_wdata = 8'h99;
    cpu_sel   = 1'b1;
    cpu_wr    = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({cpu_rdata, data_bus, write_p_data, write_p_control, write_tx_data, write_s_control,
         read_rx_data, uart_clk_i1, uart_clk_i2, irq, irq_src} !== 43'h0) begin
      errors++; $display("FAIL midop_outputs_zero: rdata %h bus %h ctrl %b irq %b",
                         cpu_rdata, data_bus, write_p_control, irq);
    end
    bus_idle();
    irq_b6[2] = 1'b0;
    tick();
    tick();
    reset    = 1'b1;
    first_i2 = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (first_i2 == 0 && uart_clk_i2[0] === 1'b1) first_i2 = c;
      checks++;
      if ({write_p_data, write_p_control, write_tx_data, write_s_control, irq} !== 13'h0) begin
        errors++; $display("FAIL midop_no_strobe cycle %0d: got %h want 0", c,
                           {write_p_data, write_p_control, write_tx_data, write_s_control, irq});
      end
    end
    checks++;
    if (first_i2 != 8) begin
      errors++; $display("FAIL midop_first_i2: got cycle %0d want 8", first_i2);
    end
  endtask

  task automatic test_baud();
    logic [3:0] exp_i1;
    logic [3:0] exp_i2;
    int         per;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 1; c <= 260; c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        per       = (k == 0) ? 8 : (k == 1) ? 16 : (k == 2) ? 32 : 128;
        exp_i2[k] = ((c % per) == 0);
        exp_i1[k] = ((c % per) == per - 4);
      end
      checks++;
      if (uart_clk_i2 !== exp_i2) begin
        errors++; $display("FAIL baud_i2 cycle %0d: got %b want %b", c, uart_clk_i2, exp_i2);
      end
      checks++;
      if (uart_clk_i1 !== exp_i1) begin
        errors++; $display("FAIL baud_i1 cycle %0d: got %b want %b", c, uart_clk_i1, exp_i1);
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    cpu_sel     = 1'b0;
    cpu_wr      = 1'b0;
    cpu_rd      = 1'b0;
    cpu_addr    = 4'd0;
    cpu_wdata   = 8'h00;
    overseas    = 1'b1;
    pal         = 1'b0;
    disk        = 1'b0;
    p_data_q    = 24'h0;
    p_control_q = 24'h0;
    p_tx_data   = 24'h0;
    p_rx_data_q = 24'h0;
    s_status    = 24'h0;
    irq_b6      = 3'b000;
    irq_uart    = 3'b000;
    irq_ack     = 1'b0;

    test_reset();
    test_version();
    test_write_strobe();
    test_rx_read();
    test_reg_reads();
    test_simultaneous();
    test_irq();
    test_reset_midop();
    test_baud();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
